// File: rtl/wb_stage.sv
// Writeback stage: selects the result, owns X0..X30, NZCV and the retired counter.
// Register file, flags and counter update on the clock edge; the bypass and forwarding outputs are combinational. There is no backpressure.
module wb_stage #(
  parameter int WORDSIZE    = 64,
  parameter int REGADDRSIZE = 5,
  parameter int FLAGSIZE    = 4,
  parameter int CONTROLSIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nop,
  input  logic [CONTROLSIZE-1:0] control,
  input  logic [WORDSIZE-1:0]    pc,
  input  logic [WORDSIZE-1:0]    alures,
  input  logic [WORDSIZE-1:0]    movres,
  input  logic [WORDSIZE-1:0]    readmem,
  input  logic [FLAGSIZE-1:0]    readflags,
  input  logic [REGADDRSIZE-1:0] rd,
  input  logic [REGADDRSIZE-1:0] readaddr1,
  input  logic [REGADDRSIZE-1:0] readaddr2,
  output logic [WORDSIZE-1:0]    readdata1,
  output logic [WORDSIZE-1:0]    readdata2,
  output logic [FLAGSIZE-1:0]    flags,
  output logic                   fwdvalid,
  output logic [REGADDRSIZE-1:0] fwdreg,
  output logic [WORDSIZE-1:0]    fwddata,
  output logic [WORDSIZE-1:0]    retired
);

  localparam logic [REGADDRSIZE-1:0] XZR = REGADDRSIZE'(31);

  logic                regwrite;
  logic [1:0]          wbsel;
  logic                flagwrite;
  logic                wen;
  logic [WORDSIZE-1:0] writedata;
  logic [WORDSIZE-1:0] regs [31];

  assign regwrite  = control[0];
  assign wbsel     = control[2:1];
  assign flagwrite = control[3];

  assign wen = regwrite & ~nop & (rd != XZR) & ~rst;

  always_comb begin
    writedata = alures;
    case (wbsel)
      2'b00:   writedata = alures;
      2'b01:   writedata = readmem;
      2'b10:   writedata = movres;
      default: writedata = pc + WORDSIZE'(4);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 31; i++) begin
        if (wen && rd == REGADDRSIZE'(i)) regs[i] <= writedata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags   <= '0;
      retired <= '0;
    end else if (!nop) begin
      if (flagwrite) flags <= readflags;
      // a regwrite to XZR still counts as a completed instruction
      if (control != '0) retired <= retired + WORDSIZE'(1);
    end
  end

  function automatic logic [WORDSIZE-1:0] rdport(input logic [REGADDRSIZE-1:0] a);
    logic [WORDSIZE-1:0] v;
    v = '0;
    if (a == XZR) begin
      v = '0;
    end else if (wen && a == rd) begin
      v = writedata;
    end else begin
      for (int i = 0; i < 31; i++) begin
        if (a == REGADDRSIZE'(i)) v = regs[i];
      end
    end
    return v;
  endfunction

  always_comb readdata1 = rdport(readaddr1);
  always_comb readdata2 = rdport(readaddr2);

  assign fwdvalid = wen;
  assign fwdreg   = rd;
  assign fwddata  = writedata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table on a 64-bit instance, hand sequences for
// reset corners, and an 8-bit instance for counter wrap and link-value truncation.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nop;
  logic [3:0]  control;
  logic [63:0] pc, alures, movres, readmem;
  logic [3:0]  readflags;
  logic [4:0]  rd, readaddr1, readaddr2;
  logic [63:0] readdata1, readdata2, fwddata, retired;
  logic [3:0]  flags;
  logic        fwdvalid;
  logic [4:0]  fwdreg;

  logic        rst8 = 1'b0;
  logic        nop8;
  logic [3:0]  control8;
  logic [7:0]  pc8, alures8, movres8, readmem8;
  logic [3:0]  readflags8;
  logic [4:0]  rd8, readaddr1_8, readaddr2_8;
  logic [7:0]  readdata1_8, readdata2_8, fwddata8, retired8;
  logic [3:0]  flags8;
  logic        fwdvalid8;
  logic [4:0]  fwdreg8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .nop(nop), .control(control), .pc(pc),
    .alures(alures), .movres(movres), .readmem(readmem), .readflags(readflags),
    .rd(rd), .readaddr1(readaddr1), .readaddr2(readaddr2),
    .readdata1(readdata1), .readdata2(readdata2), .flags(flags),
    .fwdvalid(fwdvalid), .fwdreg(fwdreg), .fwddata(fwddata), .retired(retired)
  );

  wb_stage #(.WORDSIZE(8)) dut8 (
    .clk(clk), .rst(rst8), .nop(nop8), .control(control8), .pc(pc8),
    .alures(alures8), .movres(movres8), .readmem(readmem8), .readflags(readflags8),
    .rd(rd8), .readaddr1(readaddr1_8), .readaddr2(readaddr2_8),
    .readdata1(readdata1_8), .readdata2(readdata2_8), .flags(flags8),
    .fwdvalid(fwdvalid8), .fwdreg(fwdreg8), .fwddata(fwddata8), .retired(retired8)
  );

  typedef struct {
    logic        nop;
    logic [3:0]  control;
    logic [63:0] pc, alures, movres, readmem;
    logic [3:0]  readflags;
    logic [4:0]  rd, ra1, ra2;
    logic        e_fv;
    logic [63:0] e_fd, e_rd1;
    logic [3:0]  e_flags;
    logic [63:0] e_ret, e_rd2;
  } vec_t;

  function automatic vec_t mk(
    input logic nop_i, input logic [3:0] ctl, input logic [63:0] pc_i, alu, mov, mem,
    input logic [3:0] rf, input logic [4:0] rd_i, ra1, ra2,
    input logic fv, input logic [63:0] fd, rd1, input logic [3:0] fl,
    input logic [63:0] ret, rd2);
    vec_t v;
    v.nop = nop_i; v.control = ctl; v.pc = pc_i; v.alures = alu; v.movres = mov;
    v.readmem = mem; v.readflags = rf; v.rd = rd_i; v.ra1 = ra1; v.ra2 = ra2;
    v.e_fv = fv; v.e_fd = fd; v.e_rd1 = rd1; v.e_flags = fl; v.e_ret = ret; v.e_rd2 = rd2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(1'b0, 4'b0001, 64'h0,   64'h1234, 64'h0,    64'h0,    4'h0,    5'd5,  5'd5,  5'd5,
                 1'b1, 64'h1234, 64'h1234, 4'h0,    64'd1, 64'h1234);
    vecs[1] = mk(1'b1, 4'b0011, 64'h0,   64'h0,    64'h0,    64'hDEAD, 4'h0,    5'd3,  5'd3,  5'd3,
                 1'b0, 64'hDEAD, 64'h0,    4'h0,    64'd1, 64'h0);
    vecs[2] = mk(1'b0, 4'b0111, 64'h100, 64'h0,    64'h0,    64'h0,    4'h0,    5'd30, 5'd30, 5'd5,
                 1'b1, 64'h104,  64'h104,  4'h0,    64'd2, 64'h1234);
    vecs[3] = mk(1'b0, 4'b0001, 64'h0,   64'hFF,   64'h0,    64'h0,    4'h0,    5'd31, 5'd31, 5'd30,
                 1'b0, 64'hFF,   64'h0,    4'h0,    64'd3, 64'h104);
    vecs[4] = mk(1'b0, 4'b1000, 64'h0,   64'h55,   64'h0,    64'h0,    4'b1010, 5'd7,  5'd7,  5'd7,
                 1'b0, 64'h55,   64'h0,    4'b1010, 64'd4, 64'h0);
    vecs[5] = mk(1'b0, 4'b0000, 64'h0,   64'h55,   64'h0,    64'h0,    4'b0101, 5'd7,  5'd7,  5'd7,
                 1'b0, 64'h55,   64'h0,    4'b1010, 64'd4, 64'h0);
    vecs[6] = mk(1'b0, 4'b1001, 64'h0,   64'hABCD, 64'h0,    64'h0,    4'b0101, 5'd7,  5'd7,  5'd7,
                 1'b1, 64'hABCD, 64'hABCD, 4'b0101, 64'd5, 64'hABCD);
    vecs[7] = mk(1'b0, 4'b0101, 64'h0,   64'h0,    64'h7777, 64'h0,    4'b0000, 5'd5,  5'd5,  5'd3,
                 1'b1, 64'h7777, 64'h7777, 4'b0101, 64'd6, 64'h0);
    vecs[8] = mk(1'b1, 4'b1111, 64'h0,   64'h0,    64'h0,    64'h0,    4'b0000, 5'd5,  5'd5,  5'd7,
                 1'b0, 64'h4,    64'h7777, 4'b0101, 64'd6, 64'hABCD);
    vecs[9] = mk(1'b0, 4'b0011, 64'h0,   64'h0,    64'h0,    64'hDEAD, 4'b0000, 5'd3,  5'd3,  5'd5,
                 1'b1, 64'hDEAD, 64'hDEAD, 4'b0101, 64'd7, 64'h7777);

    // reset with a would-be write pending on the inputs
    nop = 1'b0; control = 4'b0001; pc = '0; alures = 64'h1234; movres = '0; readmem = '0;
    readflags = 4'hF; rd = 5'd5; readaddr1 = 5'd5; readaddr2 = 5'd0;
    nop8 = 1'b1; control8 = '0; pc8 = '0; alures8 = '0; movres8 = '0; readmem8 = '0;
    readflags8 = '0; rd8 = '0; readaddr1_8 = '0; readaddr2_8 = '0;
    #1 rst = 1'b1; rst8 = 1'b1;
    #1;
    chk("reset_fwdvalid", 64'(fwdvalid), 64'h0);
    chk("reset_readdata1", readdata1, 64'h0);
    chk("reset_flags", 64'(flags), 64'h0);
    chk("reset_retired", retired, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_edge_readdata1", readdata1, 64'h0);
    chk("reset_edge_retired", retired, 64'h0);
    nop = 1'b1;
    #2 rst = 1'b0; rst8 = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      nop = vecs[i].nop; control = vecs[i].control; pc = vecs[i].pc;
      alures = vecs[i].alures; movres = vecs[i].movres; readmem = vecs[i].readmem;
      readflags = vecs[i].readflags; rd = vecs[i].rd;
      readaddr1 = vecs[i].ra1; readaddr2 = vecs[i].ra2;
      #2;
      chk($sformatf("v%0d_fwdvalid", i), 64'(fwdvalid), 64'(vecs[i].e_fv));
      chk($sformatf("v%0d_fwdreg", i), 64'(fwdreg), 64'(vecs[i].rd));
      chk($sformatf("v%0d_fwddata", i), fwddata, vecs[i].e_fd);
      chk($sformatf("v%0d_readdata1", i), readdata1, vecs[i].e_rd1);
      tick();
      chk($sformatf("v%0d_flags", i), 64'(flags), 64'(vecs[i].e_flags));
      chk($sformatf("v%0d_retired", i), retired, vecs[i].e_ret);
      chk($sformatf("v%0d_readdata2", i), readdata2, vecs[i].e_rd2);
    end

    // X5 <- 0x1234, then reset between edges
    nop = 1'b0; control = 4'b0001; alures = 64'h1234; rd = 5'd5;
    readaddr1 = 5'd5; readaddr2 = 5'd5;
    tick();
    nop = 1'b1;
    #1;
    chk("pre_rst_x5", readdata2, 64'h1234);
    chk("pre_rst_retired", retired, 64'd8);
    #2;
    rst = 1'b1;
    nop = 1'b0; control = 4'b1001; readflags = 4'hF;
    #1;
    chk("midrst_x5", readdata1, 64'h0);
    chk("midrst_flags", 64'(flags), 64'h0);
    chk("midrst_retired", retired, 64'h0);
    chk("midrst_fwdvalid", 64'(fwdvalid), 64'h0);
    tick();
    chk("rst_edge_x5", readdata1, 64'h0);
    chk("rst_edge_flags", 64'(flags), 64'h0);
    chk("rst_edge_retired", retired, 64'h0);
    #3 rst = 1'b0;
    tick();
    chk("post_rst_flags", 64'(flags), 64'hF);
    chk("post_rst_retired", retired, 64'd1);
    nop = 1'b1;
    #1;
    chk("post_rst_x5", readdata1, 64'h1234);

    // 8-bit instance: link value truncation and counter wrap
    nop8 = 1'b0; control8 = 4'b0111; pc8 = 8'hFE; rd8 = 5'd2; readaddr1_8 = 5'd2;
    #1;
    chk("w8_fwdvalid", 64'(fwdvalid8), 64'h1);
    chk("w8_link_trunc", 64'(fwddata8), 64'h02);
    repeat (254) tick();
    chk("w8_retired_fe", 64'(retired8), 64'hFE);
    tick();
    chk("w8_retired_ff", 64'(retired8), 64'hFF);
    tick();
    chk("w8_retired_wrap", 64'(retired8), 64'h00);
    nop8 = 1'b1;
    #1;
    chk("w8_x2", 64'(readdata1_8), 64'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wbstage

Interface
REQ-001 SHALL have parameter WORDSIZE, 64, datapath and register width.
REQ-002 SHALL have parameter REGADDRSIZE, 5, register address width.
REQ-003 SHALL have parameter FLAGSIZE, 4, NZCV flag width.
REQ-004 SHALL have parameter CONTROLSIZE, 4, width of the MEM/WB control field.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on posedge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port nop  in  1  bubble marker from the MEM/WB register; 1 = no instruction this cycle.
REQ-008 SHALL have port control  in  CONTROLSIZE  bit0 regwrite, bits[2:1] wbsel, bit3 flagwrite.
REQ-009 SHALL have port pc  in  WORDSIZE  address of the retiring instruction.
REQ-010 SHALL have ports alures, movres, readmem  in  WORDSIZE  each, the writeback candidates.
REQ-011 SHALL have port readflags  in  FLAGSIZE  flags produced by the retiring instruction.
REQ-012 SHALL have port rd  in  REGADDRSIZE  destination register.
REQ-013 SHALL have ports readaddr1, readaddr2  in  REGADDRSIZE  each, ID-stage read addresses.
REQ-014 SHALL have ports readdata1, readdata2  out  WORDSIZE  each, ID-stage read data.
REQ-015 SHALL have port flags  out  FLAGSIZE  architectural NZCV register.
REQ-016 SHALL have ports fwdvalid (1), fwdreg (REGADDRSIZE), fwddata (WORDSIZE)  out  EX-stage forwarding source.
REQ-017 SHALL have port retired  out  WORDSIZE  retired-instruction counter.

Function
REQ-018 SHALL form writedata combinationally from wbsel: 00 alures, 01 readmem, 10 movres, 11 pc+4 (BL link value, truncated to WORDSIZE).
REQ-019 SHALL define wen = regwrite & ~nop & (rd != 31) & ~rst.
REQ-020 SHALL hold 31 WORDSIZE-bit registers X0..X30; X31 (XZR) has no storage.
REQ-021 SHALL write writedata into register rd on posedge clk when wen=1; no other register changes.
REQ-022 SHALL return readdataN combinationally: 0 if readaddrN=31; writedata if wen=1 and readaddrN=rd (same-cycle bypass); otherwise the stored register.
REQ-023 SHALL load flags from readflags on posedge clk when flagwrite=1 and nop=0, else hold.
REQ-024 SHALL drive fwdvalid=wen, fwdreg=rd, fwddata=writedata combinationally, zero-latency.
REQ-025 SHALL increment retired by 1 on posedge clk when nop=0 and control!=0, wrapping from all-ones to 0.
REQ-026 SHALL treat regwrite=1 with rd=31 as a completed instruction: counted in retired, no register write, fwdvalid=0.
REQ-027 SHALL perform flag update and register write in the same cycle when both are enabled, independently.
REQ-028 SHALL ignore all writes, flag updates and counting while nop=1, regardless of control.

Reset
REQ-029 SHALL, while rst=1, immediately clear X0..X30, flags and retired to 0, independent of clk.
REQ-030 SHALL suppress any write, flag update or count on a clock edge coinciding with rst=1; the first update occurs on the first posedge after rst deasserts.
REQ-031 SHALL force fwdvalid=0 while rst=1; readdata outputs reflect the cleared registers.

Verification
REQ-032 SHALL cover: control=0001, rd=5, alures=0x1234, nop=0, one edge -> X5=0x1234, retired=1; readaddr1=5 same cycle -> readdata1=0x1234 via bypass.
REQ-033 SHALL cover: control=0011, rd=3, readmem=0xDEAD, nop=1 -> X3 unchanged, retired unchanged, fwdvalid=0.
REQ-034 SHALL cover: control=0111, pc=0x100, rd=30 -> X30=0x104; control=0001, rd=31, alures=0xFF -> readdata of X31=0, fwdvalid=0, retired incremented.
REQ-035 SHALL cover: control=1000, readflags=1010 -> flags=1010 next edge, no register written; then control=0000, readflags=0101 -> flags stay 1010, retired unchanged.
REQ-036 SHALL cover: retired preset near all-ones by 2 retirements -> wraps to 0; rst pulsed mid-clock between edges with X5=0x1234 -> X5, flags, retired read 0 before next edge.
